// File: rtl/hf_ssp_tx.sv
// Byte-to-serial transmitter feeding the ARM SSP: small byte FIFO, ssp_clk divider,
// MSB-first shifter with a frame pulse on bit 7 and no gap between queued bytes.
module hf_ssp_tx #(
  parameter int unsigned CLK_DIV    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        ck_1356meg,
  input  logic                        nrst,
  input  logic                        enable,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        clr_dropped,
  output logic                        dropped,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        ssp_clk,
  output logic                        ssp_frame,
  output logic                        ssp_din
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned DW   = $clog2(CLK_DIV);
  localparam int unsigned HALF = CLK_DIV / 2;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_div, w_div_nxt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level, w_level_nxt;
  logic [7:0]    r_sh, w_sh_nxt;
  logic [2:0]    r_bit_cnt, w_bit_nxt;
  logic          r_din, w_din_nxt;
  logic          r_frame, w_frame_nxt;
  logic          r_ssp_clk, r_in_ready, r_dropped;
  logic          w_bnd, w_push, w_pop, w_empty;
  logic [7:0]    w_head;

  assign w_bnd   = enable && (r_div == '0);
  assign w_push  = enable && in_valid && r_in_ready;
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rptr];

  assign w_div_nxt = !enable                        ? '0 :
                     (r_div == DW'(CLK_DIV - 1))    ? '0 :
                     r_div + DW'(1);

  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and shifter control; bytes load back-to-back when the FIFO has data.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_sh_nxt    = r_sh;
    w_bit_nxt   = r_bit_cnt;
    w_din_nxt   = r_din;
    w_frame_nxt = r_frame;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_sh_nxt    = '0;
      w_bit_nxt   = '0;
      w_din_nxt   = 1'b0;
      w_frame_nxt = 1'b0;
    end else if (w_bnd) begin
      if (r_state == S_IDLE || r_bit_cnt == '0) begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SHIFT;
          w_sh_nxt    = {w_head[6:0], 1'b0};
          w_din_nxt   = w_head[7];
          w_frame_nxt = 1'b1;
          w_bit_nxt   = 3'd7;
        end else begin
          w_state_nxt = S_IDLE;
          w_din_nxt   = 1'b0;
          w_frame_nxt = 1'b0;
          w_bit_nxt   = '0;
        end
      end else begin
        w_sh_nxt    = {r_sh[6:0], 1'b0};
        w_din_nxt   = r_sh[7];
        w_frame_nxt = 1'b0;
        w_bit_nxt   = r_bit_cnt - 3'd1;
      end
    end
  end

  always_comb begin
    w_level_nxt = r_level;
    if (!enable) begin
      w_level_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_level_nxt = r_level + LW'(1);
        2'b01:   w_level_nxt = r_level - LW'(1);
        default: w_level_nxt = r_level;
      endcase
    end
  end

  // Storage has no reset; occupancy and pointers define what is valid.
  always_ff @(posedge ck_1356meg) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      r_div      <= '0;
      r_ssp_clk  <= 1'b0;
      r_sh       <= '0;
      r_bit_cnt  <= '0;
      r_din      <= 1'b0;
      r_frame    <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_in_ready <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_div      <= w_div_nxt;
      r_ssp_clk  <= enable && (w_div_nxt < DW'(HALF));
      r_sh       <= w_sh_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_din      <= w_din_nxt;
      r_frame    <= w_frame_nxt;
      r_level    <= w_level_nxt;
      r_in_ready <= enable && (w_level_nxt < LW'(FIFO_DEPTH));
      if (!enable) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
      end
      // Set wins over a coincident clear.
      if (enable && in_valid && !r_in_ready) r_dropped <= 1'b1;
      else if (clr_dropped)                 r_dropped <= 1'b0;
    end
  end

  assign in_ready   = r_in_ready;
  assign dropped    = r_dropped;
  assign fifo_level = r_level;
  assign ssp_clk    = r_ssp_clk;
  assign ssp_frame  = r_frame;
  assign ssp_din    = r_din;

endmodule

// File: tb/tb_hf_ssp_tx.sv
// Bench for hf_ssp_tx: samples the serial line at ssp_clk falling edges as the ARM
// would, decodes framed bytes and compares them against a queue of pushed bytes.
module tb_hf_ssp_tx;

  localparam int unsigned CLK_DIV    = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          nrst;
  logic          enable;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          clr_dropped;
  logic          dropped;
  logic [LW-1:0] fifo_level;
  logic          ssp_clk, ssp_frame, ssp_din;

  int n_pass  = 0;
  int n_total = 0;

  logic [1:0] mon_q[$];
  logic       mon_p = 1'b0;
  logic [7:0] got[$];
  int         starts[$];
  int         bad;
  logic [7:0] model[$];

  always #5 clk = ~clk;

  hf_ssp_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .ck_1356meg (clk),
    .nrst       (nrst),
    .enable     (enable),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .clr_dropped(clr_dropped),
    .dropped    (dropped),
    .fifo_level (fifo_level),
    .ssp_clk    (ssp_clk),
    .ssp_frame  (ssp_frame),
    .ssp_din    (ssp_din)
  );

  // ARM-side view: one {frame, din} sample per ssp_clk falling edge.
  always @(negedge clk) begin
    if (mon_p && !ssp_clk) mon_q.push_back({ssp_frame, ssp_din});
    mon_p = ssp_clk;
  end

  // Split the sample stream into framed bytes; count stray frame flags and idle ones.
  task automatic decode();
    int i;
    logic [7:0] b;
    got.delete();
    starts.delete();
    bad = 0;
    i = 0;
    while (i < mon_q.size()) begin
      if (mon_q[i][1]) begin
        if (i + 8 > mon_q.size()) begin
          bad++;
          break;
        end
        b = '0;
        for (int j = 0; j < 8; j++) begin
          b = {b[6:0], mon_q[i+j][0]};
          if (j > 0 && mon_q[i+j][1]) bad++;
        end
        got.push_back(b);
        starts.push_back(i);
        i += 8;
      end else begin
        if (mon_q[i][0]) bad++;
        i++;
      end
    end
  endtask

  function automatic logic [7:0] got_at(int k);
    return (k < got.size()) ? got[k] : 8'hxx;
  endfunction

  function automatic int start_at(int k);
    return (k < starts.size()) ? starts[k] : -1000;
  endfunction

  // Returns in the cycle where the divider sits at 0 (ssp_clk just rose).
  task automatic wait_bnd();
    logic p;
    int   k;
    p = ssp_clk;
    for (k = 0; k < 4 * CLK_DIV; k++) begin
      @(negedge clk);
      if (!p && ssp_clk) break;
      p = ssp_clk;
    end
    n_total++;
    if (k == 4 * CLK_DIV) $display("FAIL wait_bnd: no ssp_clk rise within %0d cycles", k);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++; if (ssp_clk !== 1'b0) $display("FAIL rst_ssp_clk: got %b want 0", ssp_clk); else n_pass++;
    n_total++; if (ssp_frame !== 1'b0) $display("FAIL rst_frame: got %b want 0", ssp_frame); else n_pass++;
    n_total++; if (ssp_din !== 1'b0) $display("FAIL rst_din: got %b want 0", ssp_din); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
    n_total++; if (dropped !== 1'b0) $display("FAIL rst_dropped: got %b want 0", dropped); else n_pass++;
    n_total++; if (fifo_level !== LW'(0)) $display("FAIL rst_level: got %0d want 0", fifo_level); else n_pass++;
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (ssp_clk !== 1'b0) $display("FAIL dis_ssp_clk: got %b want 0", ssp_clk); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL dis_in_ready: got %b want 0", in_ready); else n_pass++;
    enable = 1'b1;
    @(negedge clk);
    // First enabled cycle is a bit boundary, so the next period starts high.
    n_total++; if (ssp_clk !== 1'b1) $display("FAIL en_ssp_clk: got %b want 1", ssp_clk); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL en_in_ready: got %b want 1", in_ready); else n_pass++;
    repeat (4 * CLK_DIV) @(negedge clk);
  endtask

  task automatic test_single();
    int d, lat;
    @(posedge clk);
    mon_q.delete();
    wait_bnd();
    d = $urandom_range(0, CLK_DIV - 1);
    repeat (d) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!ssp_frame && lat < 3 * CLK_DIV) begin
      @(negedge clk);
      lat++;
    end
    n_total++; if (lat !== CLK_DIV - d) $display("FAIL single_latency: got %0d want %0d", lat, CLK_DIV - d); else n_pass++;
    n_total++; if (ssp_din !== 1'b1) $display("FAIL single_first_bit: got %b want 1", ssp_din); else n_pass++;
    repeat (12 * CLK_DIV) @(negedge clk);
    n_total++; if ({ssp_frame, ssp_din} !== 2'b00) $display("FAIL single_idle: got %b want 00", {ssp_frame, ssp_din}); else n_pass++;
    @(posedge clk);
    decode();
    n_total++; if (got.size() !== 1) $display("FAIL single_count: got %0d want 1", got.size()); else n_pass++;
    n_total++; if (got_at(0) !== 8'hA5) $display("FAIL single_byte: got %h want a5", got_at(0)); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL single_framing: got %0d errors want 0", bad); else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    mon_q.delete();
    wait_bnd();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h01;
    @(negedge clk);
    in_data  = 8'h80;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (22 * CLK_DIV) @(negedge clk);
    @(posedge clk);
    decode();
    n_total++; if (got.size() !== 2) $display("FAIL b2b_count: got %0d want 2", got.size()); else n_pass++;
    n_total++; if (got_at(0) !== 8'h01) $display("FAIL b2b_byte0: got %h want 01", got_at(0)); else n_pass++;
    n_total++; if (got_at(1) !== 8'h80) $display("FAIL b2b_byte1: got %h want 80", got_at(1)); else n_pass++;
    n_total++; if (start_at(1) - start_at(0) !== 8) $display("FAIL b2b_gap: got %0d want 8", start_at(1) - start_at(0)); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL b2b_framing: got %0d errors want 0", bad); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    @(posedge clk);
    mon_q.delete();
    model.delete();
    wait_bnd();
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      v = 8'($urandom);
      in_valid = 1'b1;
      in_data  = v;
      n_total++; if (in_ready !== (k < 4)) $display("FAIL ovf_ready_%0d: got %b want %b", k, in_ready, k < 4); else n_pass++;
      if (k < 4) model.push_back(v);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_total++; if (dropped !== 1'b1) $display("FAIL ovf_dropped: got %b want 1", dropped); else n_pass++;
    n_total++; if (fifo_level !== LW'(4)) $display("FAIL ovf_level: got %0d want 4", fifo_level); else n_pass++;
    clr_dropped = 1'b1;
    @(negedge clk);
    clr_dropped = 1'b0;
    n_total++; if (dropped !== 1'b0) $display("FAIL ovf_clear: got %b want 0", dropped); else n_pass++;
    repeat (40 * CLK_DIV) @(negedge clk);
    @(posedge clk);
    decode();
    n_total++; if (got.size() !== 4) $display("FAIL ovf_count: got %0d want 4", got.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++; if (got_at(k) !== model[k]) $display("FAIL ovf_byte%0d: got %h want %h", k, got_at(k), model[k]); else n_pass++;
    end
    n_total++; if (start_at(3) - start_at(0) !== 24) $display("FAIL ovf_contig: got %0d want 24", start_at(3) - start_at(0)); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL ovf_framing: got %0d errors want 0", bad); else n_pass++;
  endtask

  task automatic test_push_pop();
    logic [7:0] v;
    @(posedge clk);
    mon_q.delete();
    model.delete();
    wait_bnd();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      v = 8'($urandom);
      model.push_back(v);
      in_valid = 1'b1;
      in_data  = v;
      @(negedge clk);
    end
    in_valid = 1'b0;
    // First boundary pops byte 0; eight boundaries later byte 1 is popped.
    repeat (9) wait_bnd();
    n_total++; if (fifo_level !== LW'(2)) $display("FAIL pp_level_before: got %0d want 2", fifo_level); else n_pass++;
    v = 8'($urandom);
    model.push_back(v);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
    n_total++; if (fifo_level !== LW'(2)) $display("FAIL pp_level_after: got %0d want 2", fifo_level); else n_pass++;
    repeat (30 * CLK_DIV) @(negedge clk);
    @(posedge clk);
    decode();
    n_total++; if (got.size() !== 4) $display("FAIL pp_count: got %0d want 4", got.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++; if (got_at(k) !== model[k]) $display("FAIL pp_byte%0d: got %h want %h", k, got_at(k), model[k]); else n_pass++;
    end
    n_total++; if (bad !== 0) $display("FAIL pp_framing: got %0d errors want 0", bad); else n_pass++;
  endtask

  task automatic test_enable_abort();
    @(posedge clk);
    mon_q.delete();
    wait_bnd();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clk);
    in_data  = 8'h3C;
    @(negedge clk);
    in_data  = 8'hC3;
    @(negedge clk);
    in_valid = 1'b0;
    wait_bnd();
    repeat (4) wait_bnd();
    repeat (2) @(negedge clk);
    n_total++; if (ssp_din !== 1'b1) $display("FAIL abort_bit3: got %b want 1", ssp_din); else n_pass++;
    n_total++; if (fifo_level !== LW'(2)) $display("FAIL abort_queued: got %0d want 2", fifo_level); else n_pass++;
    enable = 1'b0;
    @(negedge clk);
    n_total++; if ({ssp_clk, ssp_frame, ssp_din} !== 3'b000) $display("FAIL abort_lines: got %b want 000", {ssp_clk, ssp_frame, ssp_din}); else n_pass++;
    n_total++; if (fifo_level !== LW'(0)) $display("FAIL abort_level: got %0d want 0", fifo_level); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL abort_ready: got %b want 0", in_ready); else n_pass++;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_total++; if (dropped !== 1'b0) $display("FAIL abort_no_drop: got %b want 0", dropped); else n_pass++;
    enable = 1'b1;
    @(posedge clk);
    mon_q.delete();
    repeat (20 * CLK_DIV) @(negedge clk);
    @(posedge clk);
    decode();
    n_total++; if (got.size() !== 0) $display("FAIL abort_residual: got %0d bytes want 0", got.size()); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL abort_framing: got %0d errors want 0", bad); else n_pass++;
  endtask

  task automatic test_random();
    int n;
    logic [7:0] v;
    for (int r = 0; r < 4; r++) begin
      @(posedge clk);
      mon_q.delete();
      model.delete();
      n = $urandom_range(1, FIFO_DEPTH);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        v = 8'($urandom);
        model.push_back(v);
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        in_valid = 1'b0;
      end
      repeat ((n * 8 + 4) * CLK_DIV) @(negedge clk);
      @(posedge clk);
      decode();
      n_total++; if (got.size() !== n) $display("FAIL rnd%0d_count: got %0d want %0d", r, got.size(), n); else n_pass++;
      for (int k = 0; k < n; k++) begin
        n_total++; if (got_at(k) !== model[k]) $display("FAIL rnd%0d_byte%0d: got %h want %h", r, k, got_at(k), model[k]); else n_pass++;
      end
      n_total++; if (start_at(n - 1) - start_at(0) !== 8 * (n - 1)) $display("FAIL rnd%0d_contig: got %0d want %0d", r, start_at(n - 1) - start_at(0), 8 * (n - 1)); else n_pass++;
      n_total++; if (bad !== 0) $display("FAIL rnd%0d_framing: got %0d errors want 0", r, bad); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    wait_bnd();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clk);
    in_data  = 8'hF0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) wait_bnd();
    @(posedge clk);
    #2;
    n_total++; if (ssp_din !== 1'b1) $display("FAIL arst_pre_din: got %b want 1", ssp_din); else n_pass++;
    #1 nrst = 1'b0;
    #1;
    n_total++; if ({ssp_clk, ssp_frame, ssp_din} !== 3'b000) $display("FAIL arst_lines: got %b want 000", {ssp_clk, ssp_frame, ssp_din}); else n_pass++;
    n_total++; if (fifo_level !== LW'(0)) $display("FAIL arst_level: got %0d want 0", fifo_level); else n_pass++;
    n_total++; if ({in_ready, dropped} !== 2'b00) $display("FAIL arst_flags: got %b want 00", {in_ready, dropped}); else n_pass++;
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    mon_q.delete();
    repeat (20 * CLK_DIV) @(negedge clk);
    @(posedge clk);
    decode();
    n_total++; if (got.size() !== 0) $display("FAIL arst_residual: got %0d bytes want 0", got.size()); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL arst_framing: got %0d errors want 0", bad); else n_pass++;
  endtask

  initial begin
    nrst        = 1'b0;
    enable      = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    clr_dropped = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_pop();
    test_enable_abort();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
